// File: rtl/sram_pkg.sv
// Shared types and helpers for the multi-port SRAM controller: FSM states,
// byte-lane decode and read-lane extraction.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam int WCW = 4;

  // Returns {UB_n, LB_n}: byte address bit 0 picks the upper lane when set.
  function automatic logic [1:0] lane_sel(input logic a0);
    return a0 ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [7:0] lane_extract(input logic [15:0] d, input logic a0);
    return a0 ? d[15:8] : d[7:0];
  endfunction

endpackage

// File: rtl/sram_mport_ctrl_if.sv
// Client-side bundle of the SRAM controller: per-channel request level,
// operands, completion pulse and held read data.
interface sram_mport_ctrl_if #(
  parameter int NCH = 2,
  parameter int AW  = 19
);
  logic [NCH-1:0]    req;
  logic [NCH-1:0]    we;
  logic [NCH*AW-1:0] addr;
  logic [NCH*8-1:0]  wdata;
  logic [NCH-1:0]    ack;
  logic [NCH*8-1:0]  rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/sram_rr_arbiter.sv
// Combinational round-robin arbiter: starts searching at the channel after
// ptr (wrapping) and reports the first requester as one-hot grant plus index.
module sram_rr_arbiter #(
  parameter  int NCH = 2,
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  ptr,
  output logic [NCH-1:0] grant,
  output logic [IW-1:0]  idx,
  output logic           valid
);

  always_comb begin
    int            pos;
    logic [IW-1:0] cand;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    pos   = 0;
    cand  = '0;
    // ptr+1+i never exceeds 2*NCH-1, so a single wrap subtraction suffices.
    for (int i = 0; i < NCH; i++) begin
      pos = int'(ptr) + 1 + i;
      if (pos >= NCH) pos = pos - NCH;
      cand = IW'(pos);
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_mport_ctrl.sv
// Multi-port controller for the external 16-bit asynchronous SRAM: round-robin
// 8-bit client channels mapped onto byte lanes with configurable wait states.
module sram_mport_ctrl
  import sram_pkg::*;
#(
  parameter int NCH  = 2,
  parameter int AW   = 19,
  parameter int SAW  = 21,
  parameter int WAIT = 1
) (
  input  logic             clka,
  input  logic             reset_n,
  sram_mport_ctrl_if.slave cif,
  output logic [SAW-1:0]   SRAM_ADDR,
  inout  wire  [15:0]      SRAM_DATA,
  output logic             SRAM_WE_n,
  output logic             SRAM_OE_n,
  output logic             SRAM_UB_n,
  output logic             SRAM_LB_n
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  state_t         state;
  logic [IW-1:0]  ptr;
  logic [IW-1:0]  gidx;
  logic [IW-1:0]  arb_idx;
  logic [NCH-1:0] arb_grant;
  logic           arb_valid;
  logic [NCH-1:0] g_onehot;
  logic [NCH-1:0] ack_q;
  logic           g_we;
  logic           g_a0;
  logic [7:0]     g_wdata;
  logic           drive_en;
  logic [WCW-1:0] cnt;
  logic [7:0]     rdata_q [NCH];
  logic [AW-1:0]  sel_addr;
  logic [7:0]     sel_wdata;
  logic           sel_we;

  sram_rr_arbiter #(.NCH(NCH)) u_arb (
    .req   (cif.req),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (arb_grant[i]) begin
        sel_addr  = cif.addr[i*AW +: AW];
        sel_wdata = cif.wdata[i*8 +: 8];
        sel_we    = cif.we[i];
      end
    end
  end

  // Every pin is a register; the bus enable stays up through DONE for write hold.
  always_ff @(posedge clka or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= IW'(NCH - 1);
      gidx      <= '0;
      g_onehot  <= '0;
      g_we      <= 1'b0;
      g_a0      <= 1'b0;
      g_wdata   <= '0;
      drive_en  <= 1'b0;
      cnt       <= '0;
      ack_q     <= '0;
      SRAM_ADDR <= '0;
      SRAM_WE_n <= 1'b1;
      SRAM_OE_n <= 1'b1;
      SRAM_UB_n <= 1'b1;
      SRAM_LB_n <= 1'b1;
      for (int i = 0; i < NCH; i++) rdata_q[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            ptr                    <= arb_idx;
            gidx                   <= arb_idx;
            g_onehot               <= arb_grant;
            g_we                   <= sel_we;
            g_a0                   <= sel_addr[0];
            g_wdata                <= sel_wdata;
            SRAM_ADDR              <= SAW'(sel_addr[AW-1:1]);
            {SRAM_UB_n, SRAM_LB_n} <= lane_sel(sel_addr[0]);
            SRAM_OE_n              <= sel_we;
            SRAM_WE_n              <= ~sel_we;
            drive_en               <= sel_we;
            cnt                    <= WCW'(WAIT);
            state                  <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            if (!g_we) rdata_q[gidx] <= lane_extract(SRAM_DATA, g_a0);
            SRAM_WE_n <= 1'b1;
            SRAM_OE_n <= 1'b1;
            ack_q     <= g_onehot;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          ack_q     <= '0;
          SRAM_UB_n <= 1'b1;
          SRAM_LB_n <= 1'b1;
          drive_en  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign SRAM_DATA = drive_en ? {g_wdata, g_wdata} : 16'hzzzz;
  assign cif.ack   = ack_q;

  for (genvar i = 0; i < NCH; i++) begin : g_rdata
    assign cif.rdata[i*8 +: 8] = rdata_q[i];
  end

endmodule

// File: tb/tb_sram_mport_ctrl.sv
// Self-checking bench for sram_mport_ctrl: two instances (WAIT=1 and WAIT=3),
// each with a behavioural SRAM, checked against a byte-addressed reference memory.
module tb_sram_mport_ctrl;

  localparam int NCH = 2;
  localparam int AW  = 19;
  localparam int SAW = 21;

  logic clka    = 1'b0;
  logic reset_n = 1'b0;
  always #5 clka = ~clka;

  int checks = 0;
  int errors = 0;

  logic [NCH-1:0]    req1 = '0, we1 = '0, req3 = '0, we3 = '0;
  logic [NCH*AW-1:0] addr1 = '0, addr3 = '0;
  logic [NCH*8-1:0]  wd1 = '0, wd3 = '0;
  wire  [NCH-1:0]    ack1, ack3;
  wire  [NCH*8-1:0]  rd1, rd3;
  logic [SAW-1:0]    sa1, sa3;
  wire  [15:0]       sd1, sd3;
  logic              swe1, soe1, sub1, slb1;
  logic              swe3, soe3, sub3, slb3;

  sram_mport_ctrl_if #(.NCH(NCH), .AW(AW)) if1 ();
  sram_mport_ctrl_if #(.NCH(NCH), .AW(AW)) if3 ();

  assign if1.req   = req1;
  assign if1.we    = we1;
  assign if1.addr  = addr1;
  assign if1.wdata = wd1;
  assign ack1      = if1.ack;
  assign rd1       = if1.rdata;
  assign if3.req   = req3;
  assign if3.we    = we3;
  assign if3.addr  = addr3;
  assign if3.wdata = wd3;
  assign ack3      = if3.ack;
  assign rd3       = if3.rdata;

  sram_mport_ctrl #(.NCH(NCH), .AW(AW), .SAW(SAW), .WAIT(1)) dut1 (
    .clka(clka), .reset_n(reset_n), .cif(if1.slave),
    .SRAM_ADDR(sa1), .SRAM_DATA(sd1), .SRAM_WE_n(swe1),
    .SRAM_OE_n(soe1), .SRAM_UB_n(sub1), .SRAM_LB_n(slb1)
  );

  sram_mport_ctrl #(.NCH(NCH), .AW(AW), .SAW(SAW), .WAIT(3)) dut3 (
    .clka(clka), .reset_n(reset_n), .cif(if3.slave),
    .SRAM_ADDR(sa3), .SRAM_DATA(sd3), .SRAM_WE_n(swe3),
    .SRAM_OE_n(soe3), .SRAM_UB_n(sub3), .SRAM_LB_n(slb3)
  );

  // Behavioural async SRAMs (256 words each); writes land mid-cycle while WE_n is low.
  logic [15:0] mem1 [256];
  logic [15:0] mem3 [256];

  always @(negedge clka) begin
    if (!swe1) begin
      if (!sub1) mem1[sa1[7:0]][15:8] <= sd1[15:8];
      if (!slb1) mem1[sa1[7:0]][7:0]  <= sd1[7:0];
    end
    if (!swe3) begin
      if (!sub3) mem3[sa3[7:0]][15:8] <= sd3[15:8];
      if (!slb3) mem3[sa3[7:0]][7:0]  <= sd3[7:0];
    end
  end

  assign sd1 = (!soe1 && swe1) ? mem1[sa1[7:0]] : 16'hzzzz;
  assign sd3 = (!soe3 && swe3) ? mem3[sa3[7:0]] : 16'hzzzz;

  // While the SRAM drives the bus, the controller must not: any extra driver corrupts the word.
  always @(negedge clka) begin
    if (reset_n && !soe1) begin
      checks++;
      assert (sd1 == mem1[sa1[7:0]])
      else begin
        errors++;
        $display("[TB] FAIL bus_drive_oe1: bus=%h sram_word=%h", sd1, mem1[sa1[7:0]]);
      end
    end
    if (reset_n && !soe3) begin
      checks++;
      assert (sd3 == mem3[sa3[7:0]])
      else begin
        errors++;
        $display("[TB] FAIL bus_drive_oe3: bus=%h sram_word=%h", sd3, mem3[sa3[7:0]]);
      end
    end
  end

  // Reference model: byte-addressed memory per instance and the last served channel.
  logic [7:0] refm [2][512];
  int         last_g [2];

  typedef struct {
    int             lat;
    int             we_low;
    int             oe_low;
    logic [SAW-1:0] sa;
    logic [1:0]     lanes;
    logic [7:0]     rd;
    bit             seen;
    logic [1:0]     ack_at;
    logic [1:0]     ack_next;
  } obs_t;

  function automatic int di(input int d);
    return (d == 1) ? 0 : 1;
  endfunction

  function automatic logic [1:0] g_ack(input int d);
    return (d == 1) ? ack1 : ack3;
  endfunction

  function automatic logic [7:0] g_rdata(input int d, input int ch);
    logic [15:0] v;
    v = (d == 1) ? rd1 : rd3;
    return v[ch*8 +: 8];
  endfunction

  function automatic logic g_we(input int d);
    return (d == 1) ? swe1 : swe3;
  endfunction

  function automatic logic g_oe(input int d);
    return (d == 1) ? soe1 : soe3;
  endfunction

  function automatic logic [SAW-1:0] g_addr(input int d);
    return (d == 1) ? sa1 : sa3;
  endfunction

  function automatic logic [1:0] g_lanes(input int d);
    return (d == 1) ? {sub1, slb1} : {sub3, slb3};
  endfunction

  task automatic set_req(input int d, input int ch, input bit r, input bit w,
                         input int a, input logic [7:0] dat);
    if (d == 1) begin
      req1[ch] = r; we1[ch] = w; addr1[ch*AW +: AW] = AW'(a); wd1[ch*8 +: 8] = dat;
    end else begin
      req3[ch] = r; we3[ch] = w; addr3[ch*AW +: AW] = AW'(a); wd3[ch*8 +: 8] = dat;
    end
  endtask

  // One client transaction following the req/ack rule; returns what was observed.
  task automatic txn(input int d, input int ch, input bit w, input int a,
                     input logic [7:0] dat, output obs_t o);
    logic [1:0] ak;
    o.lat = 0; o.we_low = 0; o.oe_low = 0; o.sa = '0; o.lanes = '0;
    o.rd = '0; o.seen = 1'b0; o.ack_at = '0; o.ack_next = '0;
    @(negedge clka);
    set_req(d, ch, 1'b1, w, a, dat);
    while (!o.seen && o.lat < 40) begin
      @(negedge clka);
      o.lat++;
      if (!g_we(d)) o.we_low++;
      if (!g_oe(d)) o.oe_low++;
      if (o.lat == 1) begin
        o.sa    = g_addr(d);
        o.lanes = g_lanes(d);
      end
      ak = g_ack(d);
      if (ak[ch]) begin
        o.seen   = 1'b1;
        o.ack_at = ak;
        o.rd     = g_rdata(d, ch);
      end
    end
    set_req(d, ch, 1'b0, w, a, dat);
    @(negedge clka);
    o.ack_next = g_ack(d);
    if (o.seen) begin
      if (w) refm[di(d)][a] = dat;
      last_g[di(d)] = ch;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (sa1 !== '0) begin errors++; $display("[TB] FAIL reset_addr: got %h want 0", sa1); end
    checks++;
    if ({swe1, soe1, sub1, slb1} !== 4'hF) begin
      errors++; $display("[TB] FAIL reset_strobes1: got %b want 1111", {swe1, soe1, sub1, slb1});
    end
    checks++;
    if ({swe3, soe3, sub3, slb3} !== 4'hF) begin
      errors++; $display("[TB] FAIL reset_strobes3: got %b want 1111", {swe3, soe3, sub3, slb3});
    end
    checks++;
    if (ack1 !== 2'b00 || ack3 !== 2'b00) begin
      errors++; $display("[TB] FAIL reset_ack: got %b/%b want 00", ack1, ack3);
    end
    checks++;
    if (rd1 !== 16'h0000) begin errors++; $display("[TB] FAIL reset_rdata: got %h want 0", rd1); end
    @(negedge clka);
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clka);
      checks++;
      if ({swe1, soe1, sub1, slb1, ack1} !== 6'b111100) begin
        errors++; $display("[TB] FAIL idle_strobes: got %b want 111100", {swe1, soe1, sub1, slb1, ack1});
      end
    end
  endtask

  task automatic test_single_write_read();
    obs_t o;
    txn(1, 0, 1'b1, 3, 8'hA5, o);
    checks++;
    if (!o.seen || o.lat != 3) begin errors++; $display("[TB] FAIL wr_latency: got %0d (seen=%0d) want 3", o.lat, o.seen); end
    checks++;
    if (o.we_low != 2) begin errors++; $display("[TB] FAIL wr_we_cycles: got %0d want 2", o.we_low); end
    checks++;
    if (o.sa !== 21'h000001) begin errors++; $display("[TB] FAIL wr_sram_addr: got %h want 000001", o.sa); end
    checks++;
    if (o.lanes !== 2'b01) begin errors++; $display("[TB] FAIL wr_lanes: got %b want 01", o.lanes); end
    checks++;
    if (o.ack_at !== 2'b01 || o.ack_next !== 2'b00) begin
      errors++; $display("[TB] FAIL wr_ack_pulse: got %b then %b want 01 then 00", o.ack_at, o.ack_next);
    end
    txn(1, 0, 1'b0, 3, 8'h00, o);
    checks++;
    if (!o.seen || o.lat != 3 || o.oe_low != 2) begin
      errors++; $display("[TB] FAIL rd_timing: got lat %0d oe %0d want 3 and 2", o.lat, o.oe_low);
    end
    checks++;
    if (o.rd !== 8'hA5) begin errors++; $display("[TB] FAIL rd_data: got %h want a5", o.rd); end
  endtask

  task automatic test_lane_isolation();
    obs_t o;
    txn(1, 1, 1'b1, 2, 8'h11, o);
    txn(1, 0, 1'b1, 3, 8'h22, o);
    checks++;
    if (mem1[1] !== 16'h2211) begin errors++; $display("[TB] FAIL lane_word: got %h want 2211", mem1[1]); end
    txn(1, 1, 1'b0, 2, 8'h00, o);
    checks++;
    if (!o.seen || o.rd !== 8'h11) begin errors++; $display("[TB] FAIL lane_rd_lo: got %h want 11", o.rd); end
    txn(1, 0, 1'b0, 3, 8'h00, o);
    checks++;
    if (!o.seen || o.rd !== 8'h22) begin errors++; $display("[TB] FAIL lane_rd_hi: got %h want 22", o.rd); end
  endtask

  task automatic test_random();
    obs_t       o;
    int         ch, a;
    bit         w;
    logic [7:0] dat, rexp;
    for (int n = 0; n < 24; n++) begin
      ch   = int'($urandom_range(0, 1));
      w    = 1'($urandom_range(0, 1));
      a    = int'($urandom_range(0, 31));
      dat  = 8'($urandom);
      rexp = refm[0][a];
      txn(1, ch, w, a, dat, o);
      checks++;
      if (!o.seen || o.lat != 3) begin errors++; $display("[TB] FAIL rand_latency: got %0d want 3", o.lat); end
      checks++;
      if (o.sa !== SAW'(a / 2) || o.lanes !== ((a % 2 == 1) ? 2'b01 : 2'b10)) begin
        errors++; $display("[TB] FAIL rand_addr_lanes: got %h/%b for byte addr %0d", o.sa, o.lanes, a);
      end
      if (!w) begin
        checks++;
        if (o.rd !== rexp) begin errors++; $display("[TB] FAIL rand_rdata: got %h want %h at %0d", o.rd, rexp, a); end
      end
    end
  endtask

  task automatic test_contention();
    bit         w [2];
    int         a [2];
    logic [7:0] dat [2];
    logic [1:0] ak;
    int         t, prev_t, acks, exp_ch, got;
    @(negedge clka);
    for (int c = 0; c < 2; c++) begin
      w[c] = 1'($urandom_range(0, 1)); a[c] = int'($urandom_range(0, 31)); dat[c] = 8'($urandom);
      set_req(1, c, 1'b1, w[c], a[c], dat[c]);
    end
    t = 0; prev_t = -1; acks = 0;
    while (acks < 8 && t < 100) begin
      @(negedge clka);
      t++;
      ak = ack1;
      if (ak != 2'b00) begin
        exp_ch = (last_g[0] + 1) % 2;
        got    = ak[1] ? 1 : 0;
        checks++;
        if (ak !== (2'b01 << exp_ch)) begin
          errors++; $display("[TB] FAIL rr_order: got ack %b want channel %0d", ak, exp_ch);
        end
        if (prev_t >= 0) begin
          checks++;
          if (t - prev_t != 4) begin errors++; $display("[TB] FAIL rr_spacing: got %0d cycles want 4", t - prev_t); end
        end
        if (w[got]) refm[0][a[got]] = dat[got];
        else begin
          checks++;
          if (rd1[got*8 +: 8] !== refm[0][a[got]]) begin
            errors++; $display("[TB] FAIL rr_rdata: got %h want %h", rd1[got*8 +: 8], refm[0][a[got]]);
          end
        end
        prev_t = t; last_g[0] = got; acks++;
        w[got] = 1'($urandom_range(0, 1)); a[got] = int'($urandom_range(0, 31)); dat[got] = 8'($urandom);
        set_req(1, got, 1'b1, w[got], a[got], dat[got]);
      end
    end
    req1 = 2'b00;
    checks++;
    if (acks != 8) begin errors++; $display("[TB] FAIL rr_timeout: got %0d acks want 8", acks); end
    repeat (2) @(negedge clka);
  endtask

  task automatic test_one_cycle_requests();
    logic [1:0] ak;
    int         a [2];
    int         nacks, got, exp_ch;
    logic [7:0] rd;
    for (int it = 0; it < 2; it++) begin
      exp_ch = (last_g[0] + 1) % 2;
      a[0] = int'($urandom_range(0, 31));
      a[1] = int'($urandom_range(0, 31));
      @(negedge clka);
      set_req(1, 0, 1'b1, 1'b0, a[0], 8'h00);
      set_req(1, 1, 1'b1, 1'b0, a[1], 8'h00);
      @(negedge clka);
      req1 = 2'b00;
      nacks = 0; got = -1; rd = '0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clka);
        ak = ack1;
        if (ak != 2'b00) begin
          nacks++; got = ak[1] ? 1 : 0; rd = rd1[got*8 +: 8];
        end
      end
      checks++;
      if (nacks != 1 || got != exp_ch) begin
        errors++; $display("[TB] FAIL pulse_grant: got %0d acks on ch %0d want 1 on ch %0d", nacks, got, exp_ch);
      end
      checks++;
      if (rd !== refm[0][a[exp_ch]]) begin
        errors++; $display("[TB] FAIL pulse_rdata: got %h want %h", rd, refm[0][a[exp_ch]]);
      end
      if (got >= 0) last_g[0] = got;
    end
  endtask

  task automatic test_wait_states();
    obs_t       o;
    int         a;
    logic [7:0] dat;
    txn(3, 1, 1'b1, 5, 8'h3C, o);
    checks++;
    if (!o.seen || o.lat != 5) begin errors++; $display("[TB] FAIL w3_wr_latency: got %0d want 5", o.lat); end
    checks++;
    if (o.we_low != 4) begin errors++; $display("[TB] FAIL w3_we_cycles: got %0d want 4", o.we_low); end
    txn(3, 1, 1'b0, 5, 8'h00, o);
    checks++;
    if (!o.seen || o.lat != 5 || o.oe_low != 4) begin
      errors++; $display("[TB] FAIL w3_rd_timing: got lat %0d oe %0d want 5 and 4", o.lat, o.oe_low);
    end
    checks++;
    if (o.rd !== 8'h3C) begin errors++; $display("[TB] FAIL w3_rdata: got %h want 3c", o.rd); end
    for (int n = 0; n < 4; n++) begin
      a   = int'($urandom_range(0, 31));
      dat = 8'($urandom);
      txn(3, 0, 1'b1, a, dat, o);
      txn(3, 0, 1'b0, a, 8'h00, o);
      checks++;
      if (!o.seen || o.rd !== dat) begin errors++; $display("[TB] FAIL w3_rand: got %h want %h", o.rd, dat); end
    end
  endtask

  task automatic test_reset_midwrite();
    obs_t o;
    @(negedge clka);
    set_req(1, 1, 1'b1, 1'b1, 40, 8'h77);
    @(posedge clka);
    #2;
    checks++;
    if (swe1 !== 1'b0) begin errors++; $display("[TB] FAIL midwr_we_low: got %b want 0", swe1); end
    reset_n = 1'b0;
    #1;
    checks++;
    if (swe1 !== 1'b1 || soe1 !== 1'b1) begin
      errors++; $display("[TB] FAIL midwr_strobes: got WE_n=%b OE_n=%b want 1 1", swe1, soe1);
    end
    checks++;
    if (ack1 !== 2'b00 || rd1 !== 16'h0000) begin
      errors++; $display("[TB] FAIL midwr_ack_rdata: got %b/%h want 00/0000", ack1, rd1);
    end
    req1 = 2'b00; we1 = 2'b00;
    @(negedge clka);
    reset_n = 1'b1;
    last_g[0] = NCH - 1;
    last_g[1] = NCH - 1;
    repeat (3) begin
      @(negedge clka);
      checks++;
      if (ack1 !== 2'b00 || swe1 !== 1'b1) begin
        errors++; $display("[TB] FAIL midwr_dropped: got ack %b WE_n %b want 00 1", ack1, swe1);
      end
    end
    txn(1, 0, 1'b0, 40, 8'h00, o);
    checks++;
    if (!o.seen || o.rd !== refm[0][40]) begin
      errors++; $display("[TB] FAIL midwr_readback: got %h want %h", o.rd, refm[0][40]);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i] = '0;
      mem3[i] = '0;
    end
    for (int i = 0; i < 512; i++) begin
      refm[0][i] = '0;
      refm[1][i] = '0;
    end
    last_g[0] = NCH - 1;
    last_g[1] = NCH - 1;
    test_reset();
    test_single_write_read();
    test_lane_isolation();
    test_random();
    test_contention();
    test_one_cycle_requests();
    test_wait_states();
    test_reset_midwrite();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
